// File: rtl/rr_decoder_arbiter_if.sv
// rr_decoder_arbiter_if: request/decoder bundle between requesters and the arbiter.
// Carries timeout_err only when ARB_TIMEOUT_EN is defined.
interface rr_decoder_arbiter_if #(parameter int IDX_W = 3);
  localparam int NREQ = 1 << IDX_W;
  logic [NREQ-1:0]  req;
  logic             done;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_en_n;
  logic [NREQ-1:0]  grant;
  logic             busy;
`ifdef ARB_TIMEOUT_EN
  logic             timeout_err;
  modport master (output req, done, input sel_idx, sel_en_n, grant, busy, timeout_err);
  modport slave  (input req, done, output sel_idx, sel_en_n, grant, busy, timeout_err);
`else
  modport master (output req, done, input sel_idx, sel_en_n, grant, busy);
  modport slave  (input req, done, output sel_idx, sel_en_n, grant, busy);
`endif
endinterface

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: round-robin owner of a shared 3-to-8 decoder, break-before-make between owners.
// ARB_TIMEOUT_EN adds a forced release after TIMEOUT busy cycles with a timeout_err pulse.
module rr_decoder_arbiter #(
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  rr_decoder_arbiter_if.slave bus
);
  localparam int NREQ = 1 << IDX_W;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d, ptr_q, ptr_d, pick;
  logic [NREQ-1:0]  grant_q;
  logic             sel_en_n_q, busy_q, release_w, leave;
  // Scan downward so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    pick = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req[ptr_q + IDX_W'(i)]) pick = ptr_q + IDX_W'(i);
  end
  assign release_w = bus.done || !bus.req[sel_idx_q];
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire, terr_q, terr_d;
  assign expire = cnt_q == CNT_W'(TIMEOUT - 1);
  assign leave  = release_w || expire;
  assign cnt_d  = (state_q == BUSY) ? cnt_q + CNT_W'(1) : '0;
  assign terr_d = (state_q == BUSY) && expire && !release_w;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  assign bus.timeout_err = terr_q;
`else
  assign leave = release_w;
`endif
  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d   = BUSY;
        sel_idx_d = pick;
      end
      BUSY: state_d = leave ? GAP : BUSY;
      GAP: begin
        state_d = IDLE;
        ptr_d   = sel_idx_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from next-state so they carry no path from req/done.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      sel_idx_q  <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      sel_en_n_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
      ptr_q      <= ptr_d;
      grant_q    <= (state_d == BUSY) ? NREQ'(1) << sel_idx_d : '0;
      sel_en_n_q <= state_d != BUSY;
      busy_q     <= state_d == BUSY;
    end
  assign bus.sel_idx  = sel_idx_q;
  assign bus.sel_en_n = sel_en_n_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
endmodule
